// File: rtl/pe_simd_acc_pkg.sv
// Shared types for the SIMD multiply-accumulate processing element:
// precision modes, lane-count helper and FSM state encoding.
package pe_simd_acc_pkg;

    localparam int unsigned MAX_LANES = 4;

    typedef enum logic [1:0] {
        PREC_8B = 2'd0,
        PREC_4B = 2'd1,
        PREC_2B = 2'd2
    } prec_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC   = 3'd1,
        DRAIN = 3'd2,
        QUANT = 3'd3,
        OUT   = 3'd4
    } state_e;

    // Encoding 3 is not a real mode; it behaves as full-width single lane.
    function automatic prec_e to_prec(input logic [1:0] raw);
        return (raw == 2'd3) ? PREC_8B : prec_e'(raw);
    endfunction

    function automatic logic [2:0] lane_count(input prec_e p);
        case (p)
            PREC_4B: return 3'd2;
            PREC_2B: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/pe_lane_quant.sv
// One lane of requantisation: round-half-up arithmetic shift, optional ReLU,
// then saturation to the lane width selected by the current precision.
module pe_lane_quant
    import pe_simd_acc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [5:0]        shift,
    input  logic              relu_en,
    input  logic [1:0]        prec,
    output logic [DATA_W-1:0] q_c,
    output logic              sat_c
);

    // Two guard bits keep acc + rounding constant exact.
    localparam int unsigned XW = ACC_W + 2;

    logic signed [XW-1:0] ext;
    logic signed [XW-1:0] rnd;
    logic signed [XW-1:0] r;
    logic signed [XW-1:0] hi;
    logic signed [XW-1:0] lo;
    int unsigned          w;

    always_comb begin
        w     = DATA_W >> prec;
        ext   = XW'($signed(acc));
        rnd   = '0;
        r     = '0;
        sat_c = 1'b0;
        if (shift != 6'd0) begin
            rnd = XW'(1) <<< (shift - 6'd1);
        end
        // Shifting by ACC_W or more always rounds to zero for any accumulator value.
        if (32'(shift) < ACC_W) begin
            r = (ext + rnd) >>> shift;
        end
        if (relu_en && r[XW-1]) begin
            r = '0;
        end
        hi = (XW'(1) <<< (w - 1)) - XW'(1);
        lo = -hi - XW'(1);
        if (r > hi) begin
            r     = hi;
            sat_c = 1'b1;
        end else if (r < lo) begin
            r     = lo;
            sat_c = 1'b1;
        end
        q_c = r[DATA_W-1:0];
    end

endmodule

// File: rtl/pe_simd_acc.sv
// SIMD multiply-accumulate PE: 1/2/4 packed signed lanes, two-stage MAC
// pipeline, per-lane requantisation and a valid/ready result port.
module pe_simd_acc
    import pe_simd_acc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        PRECISION,
    input  logic              start,
    input  logic [CNT_W-1:0]  acc_len,
    input  logic [ACC_W-1:0]  input_bias,
    input  logic [5:0]        shift_fixed_point,
    input  logic              relu_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] input_activation,
    input  logic [DATA_W-1:0] input_weight,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out,
    output logic [3:0]        overflow
);

    localparam int unsigned PW = 2 * DATA_W;

    state_e                  state;
    prec_e                   prec_q;
    logic [5:0]              shift_q;
    logic                    relu_q;
    logic [CNT_W-1:0]        cnt;
    logic [ACC_W-1:0]        acc    [MAX_LANES];
    logic signed [PW-1:0]    prod_q [MAX_LANES];
    logic                    prod_vld;

    logic signed [PW-1:0]    prod_c [MAX_LANES];
    logic [DATA_W-1:0]       q_c    [MAX_LANES];
    logic [MAX_LANES-1:0]    sat_c;
    logic [MAX_LANES-1:0]    active_c;
    logic [MAX_LANES-1:0]    start_active_c;
    logic [DATA_W-1:0]       out_c;
    logic [DATA_W-1:0]       mask_c;
    logic [DATA_W-1:0]       a_raw, b_raw;
    logic signed [DATA_W-1:0] a_s, b_s;
    logic [2:0]              lanes_c;
    logic [2:0]              start_lanes_c;
    int unsigned             w_c;
    int unsigned             pad_c;

    // Lane unpacking, per-lane products and result packing for the latched mode.
    always_comb begin
        lanes_c       = lane_count(prec_q);
        start_lanes_c = lane_count(to_prec(PRECISION));
        w_c           = DATA_W >> prec_q;
        pad_c         = DATA_W - w_c;
        mask_c        = {DATA_W{1'b1}} >> pad_c;
        out_c         = '0;
        a_raw         = '0;
        b_raw         = '0;
        a_s           = '0;
        b_s           = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            active_c[i]       = (i < 32'(lanes_c));
            start_active_c[i] = (i < 32'(start_lanes_c));
            a_raw     = input_activation >> (i * w_c);
            b_raw     = input_weight >> (i * w_c);
            a_s       = $signed(a_raw << pad_c) >>> pad_c;
            b_s       = $signed(b_raw << pad_c) >>> pad_c;
            prod_c[i] = active_c[i] ? PW'(a_s) * PW'(b_s) : '0;
            if (active_c[i]) begin
                out_c = out_c | ((q_c[i] & mask_c) << (i * w_c));
            end
        end
    end

    for (genvar g = 0; g < MAX_LANES; g++) begin : g_lane
        pe_lane_quant #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_quant (
            .acc     (acc[g]),
            .shift   (shift_q),
            .relu_en (relu_q),
            .prec    (prec_q),
            .q_c     (q_c[g]),
            .sat_c   (sat_c[g])
        );
    end

    // Control FSM together with the product stage and accumulator stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            prec_q    <= PREC_8B;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            cnt       <= '0;
            prod_vld  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            overflow  <= '0;
            for (int unsigned i = 0; i < MAX_LANES; i++) begin
                acc[i]    <= '0;
                prod_q[i] <= '0;
            end
        end else begin
            prod_vld <= 1'b0;
            if (prod_vld) begin
                for (int unsigned i = 0; i < MAX_LANES; i++) begin
                    acc[i] <= acc[i] + ACC_W'(prod_q[i]);
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        prec_q   <= to_prec(PRECISION);
                        shift_q  <= shift_fixed_point;
                        relu_q   <= relu_en;
                        cnt      <= acc_len;
                        overflow <= '0;
                        for (int unsigned i = 0; i < MAX_LANES; i++) begin
                            acc[i] <= start_active_c[i] ? input_bias : '0;
                        end
                        if (acc_len == '0) begin
                            state <= DRAIN;
                        end else begin
                            state    <= ACC;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        prod_vld <= 1'b1;
                        for (int unsigned i = 0; i < MAX_LANES; i++) begin
                            prod_q[i] <= prod_c[i];
                        end
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: state <= QUANT;
                QUANT: begin
                    out       <= out_c;
                    overflow  <= sat_c & active_c;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_simd_acc.sv
// Randomised self-checking bench for pe_simd_acc against a lane-level
// arithmetic model, plus the directed scenarios with literal expectations.
module tb_pe_simd_acc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  PRECISION = '0;
    logic        start = 1'b0;
    logic [15:0] acc_len = '0;
    logic [31:0] input_bias = '0;
    logic [5:0]  shift_fixed_point = '0;
    logic        relu_en = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  input_activation = '0;
    logic [7:0]  input_weight = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out;
    logic [3:0]  overflow;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  ba [16];
    logic [7:0]  bw [16];
    logic [11:0] exp_q [$];
    logic [7:0]  last_out = '0;
    logic [3:0]  last_ovf = '0;

    pe_simd_acc #(.DATA_W(8), .ACC_W(32), .CNT_W(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .PRECISION         (PRECISION),
        .start             (start),
        .acc_len           (acc_len),
        .input_bias        (input_bias),
        .shift_fixed_point (shift_fixed_point),
        .relu_en           (relu_en),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .input_activation  (input_activation),
        .input_weight      (input_weight),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out               (out),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Reference: lanes as plain integers, int wraps like the accumulator.
    function automatic logic [11:0] model(input int prec, input int bias, input int len,
                                          input int sh, input bit relu);
        int         nl, w, acc, av, wv;
        longint     r, hi, lo;
        logic [7:0] o;
        logic [3:0] ov;
        nl = (prec == 1) ? 2 : (prec == 2) ? 4 : 1;
        w  = 8 / nl;
        o  = '0;
        ov = '0;
        for (int lane = 0; lane < nl; lane++) begin
            acc = bias;
            for (int k = 0; k < len; k++) begin
                av = (int'(ba[k]) >> (lane * w)) & ((1 << w) - 1);
                wv = (int'(bw[k]) >> (lane * w)) & ((1 << w) - 1);
                if (av >= (1 << (w - 1))) av -= (1 << w);
                if (wv >= (1 << (w - 1))) wv -= (1 << w);
                acc = acc + av * wv;
            end
            r = longint'(acc);
            if (sh > 0) r = (r + (64'sd1 <<< (sh - 1))) >>> sh;
            if (relu && r < 0) r = 0;
            hi = (64'sd1 <<< (w - 1)) - 1;
            lo = -(64'sd1 <<< (w - 1));
            if (r > hi) begin r = hi; ov[lane] = 1'b1; end
            else if (r < lo) begin r = lo; ov[lane] = 1'b1; end
            o = o | 8'((r & ((64'sd1 <<< w) - 1)) << (lane * w));
        end
        return {ov, o};
    endfunction

    // Per-cycle result checker against the expectation queue.
    always @(negedge clk) begin
        logic [11:0] e;
        if (reset && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                e = exp_q[0];
                check("out", out, e[7:0]);
                check("overflow", overflow, e[11:8]);
                check("in_ready_during_out", in_ready, 0);
                if (out_ready) begin
                    last_out = out;
                    last_ovf = overflow;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_op(input int prec, input int bias, input int len, input int sh,
                         input bit relu, input int delay, input bit gaps);
        int k, guard, lat;
        bit took;
        PRECISION         = 2'(prec);
        acc_len           = 16'(len);
        input_bias        = 32'(bias);
        shift_fixed_point = 6'(sh);
        relu_en           = relu;
        start             = 1'b1;
        @(posedge clk); #1;
        start             = 1'b0;
        PRECISION         = 2'($urandom);
        acc_len           = 16'($urandom);
        input_bias        = $urandom;
        shift_fixed_point = 6'($urandom);
        relu_en           = 1'($urandom);
        if (len > 0) begin
            check("in_ready_after_start", in_ready, 1);
            k = 0;
            guard = 0;
            while (k < len && guard < 200) begin
                if (gaps && ($urandom % 3 == 0)) begin
                    in_valid = 1'b0;
                    input_activation = 8'($urandom);
                    input_weight = 8'($urandom);
                end else begin
                    in_valid = 1'b1;
                    input_activation = ba[k];
                    input_weight = bw[k];
                end
                took = in_valid && in_ready;
                @(posedge clk); #1;
                guard++;
                if (took) k++;
            end
            in_valid = 1'b0;
            check("beats_accepted", k, len);
            check("in_ready_after_last", in_ready, 0);
        end
        exp_q.push_back(model(prec, bias, len, sh, relu));
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 3);
        acc_len = 16'd3;
        for (int i = 0; i < delay; i++) begin
            start = 1'b1;
            @(posedge clk); #1;
            check("held_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start = 1'b0;
        check("out_valid_drop", out_valid, 0);
        @(posedge clk); #1;
        check("no_restart", in_ready, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Test 1
        ba[0] = 8'd3;   bw[0] = 8'd4;
        ba[1] = 8'hFE;  bw[1] = 8'd5;
        ba[2] = 8'd7;   bw[2] = 8'd7;
        check("model_t1", model(0, 0, 3, 0, 0), 12'h033);
        do_op(0, 0, 3, 0, 0, 0, 0);
        check("t1_out", last_out, 8'h33);
        check("t1_ovf", last_ovf, 0);

        // Test 2
        check("model_t2", model(0, 1000, 0, 2, 0), 12'h17F);
        do_op(0, 1000, 0, 2, 0, 0, 0);
        check("t2_out", last_out, 8'h7F);
        check("t2_ovf", last_ovf, 1);

        // Test 3
        ba[0] = 8'h32; bw[0] = 8'h2D;
        check("model_t3", model(1, 0, 1, 0, 1), 12'h060);
        do_op(1, 0, 1, 0, 1, 0, 0);
        check("t3_out", last_out, 8'h60);

        // Test 4
        ba[0] = 8'h55; bw[0] = 8'h55;
        ba[1] = 8'h55; bw[1] = 8'h55;
        check("model_t4", model(2, 0, 2, 1, 0), 12'h055);
        do_op(2, 0, 2, 1, 0, 0, 1);
        check("t4_out", last_out, 8'h55);
        check("t4_ovf", last_ovf, 0);

        // Test 5: long back-pressure with ignored start pulses
        do_op(0, 1000, 0, 2, 0, 5, 0);
        check("t5_out", last_out, 8'h7F);

        // Test 6: reset after 2 of 4 beats
        PRECISION = 2'd0; acc_len = 16'd4; input_bias = 32'd5;
        shift_fixed_point = 6'd0; relu_en = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            input_activation = 8'd9;
            input_weight = 8'd9;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("t6_still_acc", in_ready, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("t6_in_ready", in_ready, 0);
        check("t6_out_valid", out_valid, 0);
        check("t6_out", out, 0);
        check("t6_overflow", overflow, 0);
        reset = 1'b1;
        begin
            bit seen = 1'b0;
            repeat (8) begin
                @(posedge clk); #1;
                if (out_valid) seen = 1'b1;
            end
            check("t6_no_out_valid", seen, 0);
        end

        // Randomised operations
        for (int n = 0; n < 40; n++) begin
            int prec, bias, len, sh;
            bit relu;
            prec = int'($urandom_range(0, 3));
            len  = int'($urandom_range(0, 6));
            case ($urandom % 3)
                0: bias = int'($urandom_range(0, 400)) - 200;
                1: bias = int'($urandom);
                default: bias = 0;
            endcase
            sh   = ($urandom % 4 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 8));
            relu = 1'($urandom);
            for (int k = 0; k < 16; k++) begin
                ba[k] = 8'($urandom);
                bw[k] = 8'($urandom);
            end
            do_op(prec, bias, len, sh, relu, int'($urandom_range(0, 3)), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
